// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq: each accepted ctrl token starts a burst of REPEAT beats
// (VALUE, VALUE+STEP, ...); a final beat completing can accept the next token with no bubble.
module handshake_constant_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int VALUE      = 13,
  parameter int REPEAT     = 1,
  parameter int STEP       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_last
);

  localparam int REM_W = $clog2(REPEAT + 1);
  localparam logic [DATA_WIDTH-1:0] VALUE_T = DATA_WIDTH'(VALUE);
  localparam logic [DATA_WIDTH-1:0] STEP_T  = DATA_WIDTH'(STEP);
  localparam logic [REM_W-1:0]      REM_ONE  = REM_W'(1);
  localparam logic [REM_W-1:0]      REM_FULL = REM_W'(REPEAT);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  if (REPEAT < 1 || REPEAT > 255) begin : g_bad_repeat
    $fatal(1, "handshake_constant_seq: REPEAT must be in 1..255");
  end

  logic [0:0]            state_r;
  logic [0:0]            state_nxt_s;
  logic [DATA_WIDTH-1:0] cur_r;
  logic [DATA_WIDTH-1:0] cur_nxt_s;
  logic [REM_W-1:0]      rem_r;
  logic [REM_W-1:0]      rem_nxt_s;
  logic                  last_beat_s;
  logic                  accept_s;
  logic                  xfer_s;

  // Handshake decode; ctrl_ready is gated by rst so no token slips in during reset.
  always_comb begin
    outs_valid  = (state_r == EMIT);
    last_beat_s = (rem_r == REM_ONE);
    outs_last   = outs_valid & last_beat_s;
    ctrl_ready  = rst & (~outs_valid | (last_beat_s & outs_ready));
    accept_s    = ctrl_valid & ctrl_ready;
    xfer_s      = outs_valid & outs_ready;
    if (outs_valid) begin
      outs = cur_r;
    end else begin
      outs = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state logic for the burst FSM and its beat value / countdown.
  always_comb begin
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    rem_nxt_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = EMIT;
          cur_nxt_s   = VALUE_T;
          rem_nxt_s   = REM_FULL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EMIT: begin
        if (xfer_s && last_beat_s) begin
          if (accept_s) begin
            state_nxt_s = EMIT;
            cur_nxt_s   = VALUE_T;
            rem_nxt_s   = REM_FULL;
          end else begin
            state_nxt_s = IDLE;
            cur_nxt_s   = {DATA_WIDTH{1'b0}};
            rem_nxt_s   = {REM_W{1'b0}};
          end
        end else if (xfer_s) begin
          cur_nxt_s = cur_r + STEP_T;
          rem_nxt_s = rem_r - REM_ONE;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cur_nxt_s   = {DATA_WIDTH{1'b0}};
        rem_nxt_s   = {REM_W{1'b0}};
      end
    endcase
  end

  // State registers; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cur_r   <= {DATA_WIDTH{1'b0}};
      rem_r   <= {REM_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cur_r   <= cur_nxt_s;
      rem_r   <= rem_nxt_s;
    end
  end

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: three parameterisations checked every cycle against
// a beat-index model, plus literal expectations for the documented scenarios.
module tb_handshake_constant_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cv  = 3'b000;
  logic [2:0]  cr;
  logic [2:0]  ov;
  logic [2:0]  ol;
  logic        ordy = 1'b1;
  logic [4:0]  o0;
  logic [4:0]  o1;
  logic [31:0] o2;

  int checks = 0;
  int errors = 0;

  int p_dw[3]   = '{5, 5, 32};
  int p_rep[3]  = '{3, 3, 1};
  int p_step[3] = '{1, 10, 0};

  bit busy[3];
  int idx[3];
  bit acc[3];

  always #5 clk = ~clk;

  handshake_constant_seq #(.DATA_WIDTH(5), .VALUE(13), .REPEAT(3), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(cr[0]), .outs(o0),
    .outs_valid(ov[0]), .outs_ready(ordy), .outs_last(ol[0]));
  handshake_constant_seq #(.DATA_WIDTH(5), .VALUE(13), .REPEAT(3), .STEP(10)) u1 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(cr[1]), .outs(o1),
    .outs_valid(ov[1]), .outs_ready(ordy), .outs_last(ol[1]));
  handshake_constant_seq #(.DATA_WIDTH(32), .VALUE(13), .REPEAT(1), .STEP(0)) u2 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(cr[2]), .outs(o2),
    .outs_valid(ov[2]), .outs_ready(ordy), .outs_last(ol[2]));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] act_outs(int i);
    case (i)
      0:       return {59'd0, o0};
      1:       return {59'd0, o1};
      default: return {32'd0, o2};
    endcase
  endfunction

  // Beat k of a burst carries VALUE + k*STEP reduced modulo 2^DATA_WIDTH.
  function automatic logic [63:0] exp_outs(int i);
    longint v;
    if (!busy[i]) return 64'd0;
    v = (longint'(13) + longint'(idx[i]) * longint'(p_step[i])) % (longint'(1) <<< p_dw[i]);
    return 64'(v);
  endfunction

  function automatic bit exp_last(int i);
    return busy[i] && (idx[i] == p_rep[i] - 1);
  endfunction

  function automatic bit exp_ready(int i);
    return rst && (!busy[i] || (exp_last(i) && ordy));
  endfunction

  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("outs_valid[%0d]", i), {63'd0, ov[i]}, {63'd0, busy[i]});
      chk($sformatf("outs_last[%0d]", i), {63'd0, ol[i]}, {63'd0, exp_last(i)});
      chk($sformatf("ctrl_ready[%0d]", i), {63'd0, cr[i]}, {63'd0, exp_ready(i)});
      chk($sformatf("outs[%0d]", i), act_outs(i), exp_outs(i));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      bit a;
      a = rst && cv[i] && exp_ready(i);
      acc[i] = a;
      if (!rst) begin
        busy[i] = 1'b0;
        idx[i]  = 0;
      end else if (busy[i]) begin
        if (ordy) begin
          if (idx[i] == p_rep[i] - 1) begin
            busy[i] = a;
            idx[i]  = 0;
          end else begin
            idx[i]++;
          end
        end
      end else if (a) begin
        busy[i] = 1'b1;
        idx[i]  = 0;
      end
    end
    #1;
  endtask

  // Reset takes effect without a clock edge.
  task automatic assert_rst();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busy[i] = 1'b0;
      idx[i]  = 0;
    end
    #1;
    chk("async_valid", {61'd0, ov}, 64'd0);
    chk("async_ready", {61'd0, cr}, 64'd0);
    chk("async_last", {61'd0, ol}, 64'd0);
    chk("async_outs0", act_outs(0), 64'd0);
  endtask

  initial begin
    int e0[3] = '{13, 14, 15};
    int e1[3] = '{13, 23, 1};
    for (int i = 0; i < 3; i++) begin
      busy[i] = 1'b0; idx[i] = 0; acc[i] = 1'b0;
    end
    #2;
    assert_rst();
    sample();
    chk("reset_outs_valid0", {63'd0, ov[0]}, 64'd0);
    chk("reset_ctrl_ready0", {63'd0, cr[0]}, 64'd0);
    tick();
    sample();
    tick();
    rst = 1'b1;

    // One token into each instance; instance 2 keeps its token stream up.
    cv = 3'b111;
    sample();
    chk("a_ready0", {63'd0, cr[0]}, 64'd1);
    tick();
    cv[1:0] = 2'b00;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("a_outs0", act_outs(0), 64'(e0[k]));
      chk("a_last0", {63'd0, ol[0]}, (k == 2) ? 64'd1 : 64'd0);
      chk("a_outs1_wrap", act_outs(1), 64'(e1[k]));
      chk("a_outs2", act_outs(2), 64'd13);
      chk("a_vl2", {62'd0, ov[2], ol[2]}, 64'd3);
      tick();
    end
    sample();
    chk("a_idle0", {63'd0, ov[0]}, 64'd0);
    tick();
    cv[2] = 1'b0;

    // Back-to-back bursts with ctrl_valid held for two tokens.
    cv[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      sample();
      if (k <= 5) chk("b_ready0", {63'd0, cr[0]}, (k == 0 || k == 3) ? 64'd1 : 64'd0);
      if (k >= 1) begin
        chk("b_outs0", act_outs(0), 64'(13 + (k - 1) % 3));
        chk("b_valid0", {63'd0, ov[0]}, 64'd1);
      end
      tick();
      if (k == 3) cv[0] = 1'b0;
    end
    sample();
    chk("b_idle0", {63'd0, ov[0]}, 64'd0);
    tick();

    // Backpressure on beat 2 with a pending token that must wait.
    cv[0] = 1'b1;
    sample();
    tick();
    sample();
    chk("c_beat1", act_outs(0), 64'd13);
    tick();
    ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("c_hold_outs", act_outs(0), 64'd14);
      chk("c_hold_last", {63'd0, ol[0]}, 64'd0);
      chk("c_hold_ready", {63'd0, cr[0]}, 64'd0);
      tick();
    end
    ordy = 1'b1;
    sample();
    chk("c_resume14", act_outs(0), 64'd14);
    tick();
    sample();
    chk("c_resume15", act_outs(0), 64'd15);
    chk("c_accept_next", {63'd0, cr[0]}, 64'd1);
    tick();
    cv[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      tick();
    end

    // Reset mid-burst discards the remaining beats.
    cv[0] = 1'b1;
    sample();
    tick();
    cv[0] = 1'b0;
    sample();
    chk("d_beat13", act_outs(0), 64'd13);
    tick();
    assert_rst();
    sample();
    tick();
    rst = 1'b1;
    cv[0] = 1'b1;
    sample();
    tick();
    cv[0] = 1'b0;
    sample();
    chk("d_restart13", act_outs(0), 64'd13);
    tick();
    for (int k = 0; k < 3; k++) begin
      sample();
      tick();
    end

    // Randomized traffic: producers hold ctrl_valid until accepted.
    for (int i = 0; i < 3; i++) acc[i] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (acc[i] || !cv[i]) cv[i] = ($urandom_range(0, 2) == 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 79) == 0) assert_rst();
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/handshake_constant_seq.md
HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of outs.
REQ-002 The block SHALL have parameter VALUE, default 13: first constant of each burst, truncated to DATA_WIDTH bits.
REQ-003 The block SHALL have parameter REPEAT, default 1: beats emitted per accepted ctrl token, legal range 1..255.
REQ-004 The block SHALL have parameter STEP, default 0: value added to outs between consecutive beats of a burst.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port ctrl_valid, input, 1 bit: trigger token offered.
REQ-008 The block SHALL have port ctrl_ready, output, 1 bit: trigger token accepted when high with ctrl_valid.
REQ-009 The block SHALL have port outs, output, DATA_WIDTH bits: current beat value.
REQ-010 The block SHALL have port outs_valid, output, 1 bit: outs carries a valid beat.
REQ-011 The block SHALL have port outs_ready, input, 1 bit: consumer accepts the beat.
REQ-012 The block SHALL have port outs_last, output, 1 bit: high on the final beat of a burst.
REQ-013 The block SHALL fail elaboration when REPEAT is 0 or greater than 255.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE (no burst) and EMIT (burst in progress).
REQ-015 The block SHALL hold registers cur (DATA_WIDTH bits) and rem (beats remaining, width clog2(REPEAT+1)).
REQ-016 Token acceptance SHALL occur in a cycle where ctrl_valid and ctrl_ready are both high.
REQ-017 ctrl_ready SHALL be high in IDLE, and in EMIT only when rem equals 1 and outs_ready is high (final beat completing), giving zero-bubble back-to-back bursts.
REQ-018 On acceptance, next edge: state EMIT, cur = VALUE, rem = REPEAT.
REQ-019 outs_valid SHALL be high exactly when state is EMIT; first beat appears one cycle after acceptance.
REQ-020 outs SHALL equal cur when outs_valid is high and 0 otherwise.
REQ-021 outs_last SHALL equal outs_valid AND (rem equals 1).
REQ-022 On a beat transfer (outs_valid and outs_ready) with rem > 1: cur = cur + STEP modulo 2^DATA_WIDTH, rem = rem - 1.
REQ-023 On a beat transfer with rem equal to 1 and no simultaneous acceptance: state IDLE, cur = 0, rem = 0.
REQ-024 On a final-beat transfer with simultaneous acceptance: state stays EMIT, cur = VALUE, rem = REPEAT.
REQ-025 While outs_valid is high and outs_ready is low: outs, outs_last, cur and rem SHALL hold stable; no token accepted.
REQ-026 ctrl_valid in EMIT before the final beat SHALL be ignored (held off by ctrl_ready low), with no token loss.
REQ-027 Sustained throughput SHALL be one beat per cycle; token rate is one per REPEAT cycles under no backpressure.
REQ-028 STEP SHALL be truncated to DATA_WIDTH bits; the add wraps silently, with no overflow flag.
REQ-029 REPEAT=1, STEP=0 SHALL behave as a registered constant source: one beat of VALUE per token, with outs_last always equal to outs_valid.

Reset
REQ-030 rst low SHALL immediately, without a clock, force: state IDLE, cur 0, rem 0, outs_valid 0, outs 0, outs_last 0, ctrl_ready 0.
REQ-031 ctrl_ready SHALL be gated low while rst is low; it rises in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-burst SHALL abort the burst; the remaining beats are discarded and not replayed.
REQ-033 No token SHALL be accepted in a cycle where rst is low.

Verification
REQ-034 DATA_WIDTH=5, VALUE=13, REPEAT=3, STEP=1, outs_ready=1, one token at cycle 0 -> outs 13,14,15 in cycles 1-3; outs_last only in cycle 3; IDLE in cycle 4.
REQ-035 Same parameters but STEP=10 -> outs 13,23,1 (33 wraps mod 32).
REQ-036 Backpressure: outs_ready low for 4 cycles on beat 2 -> outs stays 14, outs_last stays 0, ctrl_ready stays 0; sequence resumes 14,15 once ready rises.
REQ-037 Back-to-back: ctrl_valid held high for 2 tokens -> 6 consecutive beats 13,14,15,13,14,15 with no bubble; ctrl_ready high only in cycles 0 and 3.
REQ-038 Reset mid-burst: rst low after beat 13 -> outs_valid 0 asynchronously; after release a new token restarts at 13.
REQ-039 REPEAT=1, STEP=0, DATA_WIDTH=32, continuous tokens -> outs=13 with outs_valid and outs_last high every cycle from cycle 1.
